csr_mtrap: RTL and testbench

CSR_MTRAP -- requirements
Module: csr_mtrap

---
 rtl/csr_mtrap.sv | 247 ++++++++++++++++++++++++
 tb/tb_csr_mtrap.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_mtrap.sv
// csr_mtrap - machine-mode CSR file with trap/interrupt entry and mret return.
//
// Parameters
//   XLEN        : CSR and PC width
//   CNT_WIDTH   : mcycle / minstret width (32..XLEN), zero-extended on read
//   VECTORED_EN : 1 allows mtvec.MODE=01 (vectored interrupts), 0 forces MODE=00
//
// Ports
//   clk, rst                 : clock, synchronous active-high reset
//   pc_i                     : PC of the instruction at the commit point
//   csr_rd_en, csr_wr_en     : CSR access request strobes
//   csr_idx, wbck_csr_data   : CSR address and write data
//   read_csr_data            : combinational read data (0 unless csr_rd_en)
//   csr_illegal              : access to an unimplemented CSR address
//   ecall_trap_ena, exc_ena  : ecall / synchronous exception at commit
//   exc_cause, exc_tval      : exception code and trap value
//   mret_ena                 : mret at commit
//   instr_retire             : one instruction retired this cycle
//   stall                    : commit stage stalled; blocks trap/mret/context writes
//   msip_i, mtip_i, meip_i   : level-sensitive interrupt lines
//   redirect_valid/pc        : fetch redirect for trap entry or mret
//   trap_taken               : trap accepted this cycle
module csr_mtrap #(
    parameter int XLEN        = 64,
    parameter int CNT_WIDTH   = 64,
    parameter bit VECTORED_EN = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pc_i,
    input  logic            csr_rd_en,
    input  logic            csr_wr_en,
    input  logic [11:0]     csr_idx,
    input  logic [XLEN-1:0] wbck_csr_data,
    output logic [XLEN-1:0] read_csr_data,
    output logic            csr_illegal,
    input  logic            ecall_trap_ena,
    input  logic            exc_ena,
    input  logic [3:0]      exc_cause,
    input  logic [XLEN-1:0] exc_tval,
    input  logic            mret_ena,
    input  logic            instr_retire,
    input  logic            stall,
    input  logic            msip_i,
    input  logic            mtip_i,
    input  logic            meip_i,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic            trap_taken
);

    localparam logic [11:0] A_MSTATUS  = 12'h300;
    localparam logic [11:0] A_MIE      = 12'h304;
    localparam logic [11:0] A_MTVEC    = 12'h305;
    localparam logic [11:0] A_MCOUNTIN = 12'h320;
    localparam logic [11:0] A_MSCRATCH = 12'h340;
    localparam logic [11:0] A_MEPC     = 12'h341;
    localparam logic [11:0] A_MCAUSE   = 12'h342;
    localparam logic [11:0] A_MTVAL    = 12'h343;
    localparam logic [11:0] A_MIP      = 12'h344;
    localparam logic [11:0] A_MCYCLE   = 12'hB00;
    localparam logic [11:0] A_MINSTRET = 12'hB02;

    logic                 mstatus_mie, mstatus_mpie;
    logic                 mie_msie, mie_mtie, mie_meie;
    logic                 mip_msip, mip_mtip, mip_meip;
    logic                 inhibit_cy, inhibit_ir;
    logic [XLEN-1:0]      mtvec, mscratch, mepc, mcause, mtval;
    logic [CNT_WIDTH-1:0] mcycle, minstret;

    logic [XLEN-1:0] rd_val;
    logic            csr_hit;
    logic            wr_mstatus, wr_mie, wr_mtvec, wr_mcountin, wr_mscratch;
    logic            wr_mepc, wr_mcause, wr_mtval, wr_mcycle, wr_minstret;
    logic [1:0]      mtvec_mode_wr;

    logic            pend_msi, pend_mti, pend_mei;
    logic            irq_req, trap_src, trap_fire, mret_fire;
    logic            trap_intr;
    logic [3:0]      trap_code;
    logic [XLEN-1:0] trap_cause, tvec_base, trap_pc;

    // ---------------- read mux / decode ----------------
    always_comb begin
        rd_val  = '0;
        csr_hit = 1'b1;
        case (csr_idx)
            A_MSTATUS: begin
                rd_val[3]     = mstatus_mie;
                rd_val[7]     = mstatus_mpie;
                rd_val[12:11] = 2'b11;
            end
            A_MIE: begin
                rd_val[3]  = mie_msie;
                rd_val[7]  = mie_mtie;
                rd_val[11] = mie_meie;
            end
            A_MTVEC:    rd_val = mtvec;
            A_MSCRATCH: rd_val = mscratch;
            A_MEPC:     rd_val = mepc;
            A_MCAUSE:   rd_val = mcause;
            A_MTVAL:    rd_val = mtval;
            A_MIP: begin
                rd_val[3]  = mip_msip;
                rd_val[7]  = mip_mtip;
                rd_val[11] = mip_meip;
            end
            A_MCOUNTIN: begin
                rd_val[0] = inhibit_cy;
                rd_val[2] = inhibit_ir;
            end
            A_MCYCLE:   rd_val[CNT_WIDTH-1:0] = mcycle;
            A_MINSTRET: rd_val[CNT_WIDTH-1:0] = minstret;
            default:    csr_hit = 1'b0;
        endcase
    end

    assign read_csr_data = csr_rd_en ? rd_val : '0;
    assign csr_illegal   = (csr_rd_en | csr_wr_en) & ~csr_hit & ~rst;

    assign wr_mstatus  = csr_wr_en && (csr_idx == A_MSTATUS);
    assign wr_mie      = csr_wr_en && (csr_idx == A_MIE);
    assign wr_mtvec    = csr_wr_en && (csr_idx == A_MTVEC);
    assign wr_mcountin = csr_wr_en && (csr_idx == A_MCOUNTIN);
    assign wr_mscratch = csr_wr_en && (csr_idx == A_MSCRATCH);
    assign wr_mepc     = csr_wr_en && (csr_idx == A_MEPC);
    assign wr_mcause   = csr_wr_en && (csr_idx == A_MCAUSE);
    assign wr_mtval    = csr_wr_en && (csr_idx == A_MTVAL);
    assign wr_mcycle   = csr_wr_en && (csr_idx == A_MCYCLE);
    assign wr_minstret = csr_wr_en && (csr_idx == A_MINSTRET);

    // Only 00 and (when supported) 01 are legal modes; everything else collapses to direct.
    assign mtvec_mode_wr = (VECTORED_EN && (wbck_csr_data[1:0] == 2'b01)) ? 2'b01 : 2'b00;

    // ---------------- trap selection ----------------
    assign pend_msi = mip_msip & mie_msie;
    assign pend_mti = mip_mtip & mie_mtie;
    assign pend_mei = mip_meip & mie_meie;

    // A zero PC marks an empty commit slot, so interrupts are not taken there.
    assign irq_req  = (pend_msi | pend_mti | pend_mei) & mstatus_mie & (pc_i != '0);
    assign trap_src = exc_ena | ecall_trap_ena | irq_req;

    always_comb begin
        trap_intr = 1'b0;
        trap_code = 4'd0;
        if (exc_ena) begin
            trap_code = exc_cause;
        end else if (ecall_trap_ena) begin
            trap_code = 4'd11;
        end else if (pend_mei) begin
            trap_intr = 1'b1;
            trap_code = 4'd11;
        end else if (pend_msi) begin
            trap_intr = 1'b1;
            trap_code = 4'd3;
        end else begin
            trap_intr = 1'b1;
            trap_code = 4'd7;
        end
    end

    always_comb begin
        trap_cause          = '0;
        trap_cause[XLEN-1]  = trap_intr;
        trap_cause[3:0]     = trap_code;
    end

    assign trap_fire = trap_src & ~stall & ~rst;
    // A trap in the same cycle cancels the mret.
    assign mret_fire = mret_ena & ~stall & ~trap_fire & ~rst;

    assign tvec_base = {mtvec[XLEN-1:2], 2'b00};
    assign trap_pc   = (trap_intr && (mtvec[1:0] == 2'b01))
                     ? tvec_base + XLEN'({trap_code, 2'b00})
                     : tvec_base;

    assign trap_taken     = trap_fire;
    assign redirect_valid = trap_fire | mret_fire;
    assign redirect_pc    = trap_fire ? trap_pc : mepc;

    // ---------------- state ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            mstatus_mie  <= 1'b0;
            mstatus_mpie <= 1'b0;
            mie_msie     <= 1'b0;
            mie_mtie     <= 1'b0;
            mie_meie     <= 1'b0;
            mip_msip     <= 1'b0;
            mip_mtip     <= 1'b0;
            mip_meip     <= 1'b0;
            inhibit_cy   <= 1'b0;
            inhibit_ir   <= 1'b0;
            mtvec        <= '0;
            mscratch     <= '0;
            mepc         <= '0;
            mcause       <= '0;
            mtval        <= '0;
            mcycle       <= '0;
            minstret     <= '0;
        end else begin
            mip_msip <= msip_i;
            mip_mtip <= mtip_i;
            mip_meip <= meip_i;

            if (wr_mie) begin
                mie_msie <= wbck_csr_data[3];
                mie_mtie <= wbck_csr_data[7];
                mie_meie <= wbck_csr_data[11];
            end
            if (wr_mtvec)    mtvec    <= {wbck_csr_data[XLEN-1:2], mtvec_mode_wr};
            if (wr_mscratch) mscratch <= wbck_csr_data;
            if (wr_mcountin) begin
                inhibit_cy <= wbck_csr_data[0];
                inhibit_ir <= wbck_csr_data[2];
            end

            if (wr_mcycle)        mcycle <= wbck_csr_data[CNT_WIDTH-1:0];
            else if (!inhibit_cy) mcycle <= mcycle + CNT_WIDTH'(1);

            if (wr_minstret)                       minstret <= wbck_csr_data[CNT_WIDTH-1:0];
            else if (instr_retire && !inhibit_ir) minstret <= minstret + CNT_WIDTH'(1);

            // Trap context: trap beats mret beats software writes; all frozen while stalled.
            if (trap_fire) begin
                mepc         <= {pc_i[XLEN-1:2], 2'b00};
                mcause       <= trap_cause;
                mtval        <= exc_ena ? exc_tval : '0;
                mstatus_mpie <= mstatus_mie;
                mstatus_mie  <= 1'b0;
            end else if (mret_fire) begin
                mstatus_mie  <= mstatus_mpie;
                mstatus_mpie <= 1'b1;
            end else if (!stall) begin
                if (wr_mstatus) begin
                    mstatus_mie  <= wbck_csr_data[3];
                    mstatus_mpie <= wbck_csr_data[7];
                end
                if (wr_mepc)   mepc   <= {wbck_csr_data[XLEN-1:2], 2'b00};
                if (wr_mcause) mcause <= wbck_csr_data;
                if (wr_mtval)  mtval  <= wbck_csr_data;
            end
        end
    end

endmodule

// File: tb/tb_csr_mtrap.sv
module tb_csr_mtrap;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] pc_i;
    logic        csr_rd_en, csr_wr_en;
    logic [11:0] csr_idx;
    logic [63:0] wbck_csr_data;
    logic        ecall_trap_ena, exc_ena, mret_ena, instr_retire, stall;
    logic [3:0]  exc_cause;
    logic [63:0] exc_tval;
    logic        msip_i, mtip_i, meip_i;

    logic [63:0] read_csr_data, redirect_pc;
    logic        csr_illegal, redirect_valid, trap_taken;
    logic [63:0] nv_read_csr_data, nv_redirect_pc;
    logic        nv_csr_illegal, nv_redirect_valid, nv_trap_taken;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    csr_mtrap #(.XLEN(64), .CNT_WIDTH(32), .VECTORED_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .pc_i(pc_i),
        .csr_rd_en(csr_rd_en), .csr_wr_en(csr_wr_en), .csr_idx(csr_idx),
        .wbck_csr_data(wbck_csr_data), .read_csr_data(read_csr_data),
        .csr_illegal(csr_illegal), .ecall_trap_ena(ecall_trap_ena),
        .exc_ena(exc_ena), .exc_cause(exc_cause), .exc_tval(exc_tval),
        .mret_ena(mret_ena), .instr_retire(instr_retire), .stall(stall),
        .msip_i(msip_i), .mtip_i(mtip_i), .meip_i(meip_i),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .trap_taken(trap_taken)
    );

    csr_mtrap #(.XLEN(64), .CNT_WIDTH(32), .VECTORED_EN(1'b0)) dut_nv (
        .clk(clk), .rst(rst), .pc_i(pc_i),
        .csr_rd_en(csr_rd_en), .csr_wr_en(csr_wr_en), .csr_idx(csr_idx),
        .wbck_csr_data(wbck_csr_data), .read_csr_data(nv_read_csr_data),
        .csr_illegal(nv_csr_illegal), .ecall_trap_ena(ecall_trap_ena),
        .exc_ena(exc_ena), .exc_cause(exc_cause), .exc_tval(exc_tval),
        .mret_ena(mret_ena), .instr_retire(instr_retire), .stall(stall),
        .msip_i(msip_i), .mtip_i(mtip_i), .meip_i(meip_i),
        .redirect_valid(nv_redirect_valid), .redirect_pc(nv_redirect_pc),
        .trap_taken(nv_trap_taken)
    );

    // Reference state, held as architectural CSR values.
    bit          m_mie, m_mpie, m_cy, m_ir;
    logic [63:0] m_ie, m_ip, m_tvec, m_scratch, m_epc, m_cause, m_tval;
    logic [31:0] m_cycle, m_instret;
    bit          e_trap, e_mret, e_intr;
    logic [3:0]  e_code;

    logic [11:0] idx_tab [0:10] = '{12'h300, 12'h304, 12'h305, 12'h320, 12'h340,
                                    12'h341, 12'h342, 12'h343, 12'h344, 12'hB00, 12'hB02};

    task automatic model_reset();
        m_mie = 0; m_mpie = 0; m_cy = 0; m_ir = 0;
        m_ie = 0; m_ip = 0; m_tvec = 0; m_scratch = 0; m_epc = 0; m_cause = 0; m_tval = 0;
        m_cycle = 0; m_instret = 0;
    endtask

    function automatic logic [63:0] model_read(input logic [11:0] idx, input bit nv);
        case (idx)
            12'h300: return 64'h1800 | (64'(m_mie) << 3) | (64'(m_mpie) << 7);
            12'h304: return m_ie;
            12'h305: return nv ? (m_tvec & ~64'h3) : m_tvec;
            12'h320: return 64'(m_cy) | (64'(m_ir) << 2);
            12'h340: return m_scratch;
            12'h341: return m_epc;
            12'h342: return m_cause;
            12'h343: return m_tval;
            12'h344: return m_ip;
            12'hB00: return {32'h0, m_cycle};
            12'hB02: return {32'h0, m_instret};
            default: return 64'h0;
        endcase
    endfunction

    function automatic bit model_legal(input logic [11:0] idx);
        return idx inside {12'h300, 12'h304, 12'h305, 12'h320, 12'h340, 12'h341,
                           12'h342, 12'h343, 12'h344, 12'hB00, 12'hB02};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        logic [63:0] pend, base, tgt, nv_tgt;
        bit irq, ill;
        pend   = m_ip & m_ie;
        irq    = (pend != 0) && m_mie && (pc_i != 0);
        e_intr = 0;
        e_code = 0;
        if (exc_ena)             e_code = exc_cause;
        else if (ecall_trap_ena) e_code = 4'd11;
        else if (pend[11])       begin e_intr = 1; e_code = 4'd11; end
        else if (pend[3])        begin e_intr = 1; e_code = 4'd3;  end
        else                     begin e_intr = 1; e_code = 4'd7;  end
        e_trap = !rst && !stall && (exc_ena || ecall_trap_ena || irq);
        e_mret = !rst && !stall && !e_trap && mret_ena;
        base   = m_tvec & ~64'h3;
        if (!e_trap)                              tgt = m_epc;
        else if (e_intr && m_tvec[1:0] == 2'b01) tgt = base + 64'(e_code) * 4;
        else                                      tgt = base;
        nv_tgt = e_trap ? base : m_epc;
        ill    = !rst && (csr_rd_en || csr_wr_en) && !model_legal(csr_idx);

        chk("trap_taken", trap_taken, e_trap);
        chk("redirect_valid", redirect_valid, e_trap || e_mret);
        if (e_trap || e_mret) chk("redirect_pc", redirect_pc, tgt);
        chk("csr_illegal", csr_illegal, ill);
        chk("read_data", read_csr_data, csr_rd_en ? model_read(csr_idx, 0) : 64'h0);
        chk("nv_trap_taken", nv_trap_taken, e_trap);
        chk("nv_redirect_valid", nv_redirect_valid, e_trap || e_mret);
        if (e_trap || e_mret) chk("nv_redirect_pc", nv_redirect_pc, nv_tgt);
        chk("nv_csr_illegal", nv_csr_illegal, ill);
        chk("nv_read_data", nv_read_csr_data, csr_rd_en ? model_read(csr_idx, 1) : 64'h0);
    endtask

    task automatic model_update();
        logic [63:0] w;
        w = wbck_csr_data;
        if (rst) begin
            model_reset();
            return;
        end
        if (csr_wr_en && csr_idx == 12'hB00) m_cycle = w[31:0];
        else if (!m_cy)                      m_cycle = m_cycle + 1;
        if (csr_wr_en && csr_idx == 12'hB02) m_instret = w[31:0];
        else if (instr_retire && !m_ir)      m_instret = m_instret + 1;

        if (e_trap) begin
            m_epc   = pc_i & ~64'h3;
            m_cause = (64'(e_intr) << 63) | 64'(e_code);
            m_tval  = exc_ena ? exc_tval : 64'h0;
            m_mpie  = m_mie;
            m_mie   = 0;
        end else if (e_mret) begin
            m_mie  = m_mpie;
            m_mpie = 1;
        end else if (!stall && csr_wr_en) begin
            case (csr_idx)
                12'h300: begin m_mie = w[3]; m_mpie = w[7]; end
                12'h341: m_epc   = w & ~64'h3;
                12'h342: m_cause = w;
                12'h343: m_tval  = w;
                default: ;
            endcase
        end
        if (csr_wr_en) begin
            case (csr_idx)
                12'h304: m_ie      = w & 64'h888;
                12'h305: m_tvec    = (w & ~64'h3) | ((w[1:0] == 2'b01) ? 64'h1 : 64'h0);
                12'h340: m_scratch = w;
                12'h320: begin m_cy = w[0]; m_ir = w[2]; end
                default: ;
            endcase
        end
        m_ip = (64'(meip_i) << 11) | (64'(mtip_i) << 7) | (64'(msip_i) << 3);
    endtask

    task automatic cycle();
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic wr(input logic [11:0] idx, input logic [63:0] d);
        csr_wr_en = 1; csr_idx = idx; wbck_csr_data = d;
        cycle();
        csr_wr_en = 0;
    endtask

    task automatic rd(input string tag, input logic [11:0] idx, input logic [63:0] exp);
        csr_rd_en = 1; csr_idx = idx;
        #1;
        chk(tag, read_csr_data, exp);
        cycle();
        csr_rd_en = 0;
    endtask

    initial begin
        rst = 1; pc_i = 64'h8000_0100;
        csr_rd_en = 0; csr_wr_en = 0; csr_idx = 0; wbck_csr_data = 0;
        ecall_trap_ena = 0; exc_ena = 0; exc_cause = 0; exc_tval = 0;
        mret_ena = 0; instr_retire = 0; stall = 0;
        msip_i = 0; mtip_i = 0; meip_i = 0;
        model_reset();
        cycle();
        cycle();
        rst = 0;

        // reset values
        rd("rst_mstatus", 12'h300, 64'h1800);
        rd("rst_mtvec",   12'h305, 64'h0);
        rd("rst_mepc",    12'h341, 64'h0);
        rd("rst_mip",     12'h344, 64'h0);

        // vectored timer interrupt
        wr(12'h305, 64'h8000_0001);
        wr(12'h304, 64'h80);
        wr(12'h300, 64'h8);
        mtip_i = 1;
        #1 chk("mti_no_trap_yet", trap_taken, 1'b0);
        cycle();
        #1;
        chk("mti_trap", trap_taken, 1'b1);
        chk("mti_redirect", redirect_pc, 64'h8000_001C);
        cycle();
        mtip_i = 0;
        rd("mti_mcause",  12'h342, 64'h8000_0000_0000_0007);
        rd("mti_mepc",    12'h341, 64'h8000_0100);
        rd("mti_mstatus", 12'h300, 64'h1880);

        // MEI beats MSI, then mret
        wr(12'h304, 64'h888);
        wr(12'h300, 64'h8);
        msip_i = 1; meip_i = 1;
        cycle();
        #1;
        chk("mei_trap", trap_taken, 1'b1);
        chk("mei_redirect", redirect_pc, 64'h8000_002C);
        cycle();
        msip_i = 0; meip_i = 0;
        rd("mei_mcause", 12'h342, 64'h8000_0000_0000_000B);
        cycle();
        mret_ena = 1;
        #1;
        chk("mret_valid", redirect_valid, 1'b1);
        chk("mret_pc", redirect_pc, 64'h8000_0100);
        cycle();
        mret_ena = 0;
        rd("mret_mstatus", 12'h300, 64'h1888);

        // exception beats pending timer interrupt
        mtip_i = 1;
        cycle();
        exc_ena = 1; exc_cause = 4'd2; exc_tval = 64'hDEAD;
        #1;
        chk("exc_trap", trap_taken, 1'b1);
        chk("exc_redirect", redirect_pc, 64'h8000_0000);
        cycle();
        exc_ena = 0; mtip_i = 0;
        rd("exc_mcause", 12'h342, 64'h2);
        rd("exc_mtval",  12'h343, 64'hDEAD);

        // 32-bit counter wrap and inhibit
        wr(12'hB00, 64'hFFFF_FFFF);
        rd("cy_max",  12'hB00, 64'hFFFF_FFFF);
        rd("cy_wrap", 12'hB00, 64'h0);
        wr(12'h320, 64'h1);
        wr(12'hB00, 64'h5);
        rd("cy_hold0", 12'hB00, 64'h5);
        rd("cy_hold1", 12'hB00, 64'h5);
        wr(12'h320, 64'h0);

        // stalled trap
        pc_i = 64'h1234_5677;
        ecall_trap_ena = 1; stall = 1; csr_rd_en = 1; csr_idx = 12'h341;
        repeat (3) begin
            #1;
            chk("stall_trap", trap_taken, 1'b0);
            chk("stall_mepc", read_csr_data, 64'h8000_0100);
            cycle();
        end
        stall = 0;
        #1 chk("unstall_trap", trap_taken, 1'b1);
        cycle();
        ecall_trap_ena = 0; csr_rd_en = 0;
        rd("ecall_mepc",   12'h341, 64'h1234_5674);
        rd("ecall_mcause", 12'h342, 64'hB);

        // illegal address, mtvec mode legalisation
        csr_rd_en = 1; csr_idx = 12'h7C0;
        #1;
        chk("illegal_flag", csr_illegal, 1'b1);
        chk("illegal_data", read_csr_data, 64'h0);
        cycle();
        csr_rd_en = 0;
        wr(12'h305, 64'h3);
        rd("mtvec_mode3", 12'h305, 64'h0);
        wr(12'h305, 64'h8000_0001);
        csr_rd_en = 1; csr_idx = 12'h305;
        #1;
        chk("nv_mtvec", nv_read_csr_data, 64'h8000_0000);
        chk("v_mtvec", read_csr_data, 64'h8000_0001);
        cycle();
        csr_rd_en = 0;

        // randomized traffic against the reference model
        for (int n = 0; n < 600; n++) begin
            pc_i           = ($urandom_range(0, 7) == 0) ? 64'h0 : {$urandom, $urandom};
            csr_rd_en      = ($urandom_range(0, 1) == 1);
            csr_wr_en      = ($urandom_range(0, 3) == 0);
            csr_idx        = ($urandom_range(0, 11) == 11) ? 12'($urandom) : idx_tab[$urandom_range(0, 10)];
            wbck_csr_data  = {$urandom, $urandom};
            exc_ena        = ($urandom_range(0, 9) == 0);
            exc_cause      = 4'($urandom_range(0, 15));
            exc_tval       = {$urandom, $urandom};
            ecall_trap_ena = ($urandom_range(0, 9) == 0);
            mret_ena       = ($urandom_range(0, 5) == 0);
            stall          = ($urandom_range(0, 3) == 0);
            instr_retire   = ($urandom_range(0, 1) == 1);
            msip_i         = ($urandom_range(0, 2) == 0);
            mtip_i         = ($urandom_range(0, 2) == 0);
            meip_i         = ($urandom_range(0, 2) == 0);
            rst            = ($urandom_range(0, 99) == 0);
            cycle();
        end

        // reset beats trap, illegal flag and writes
        pc_i = 64'h8000_0100; stall = 0; mret_ena = 0; exc_ena = 0; csr_wr_en = 0;
        rst = 1; ecall_trap_ena = 1; csr_rd_en = 1; csr_idx = 12'h7C0;
        #1;
        chk("rst_trap", trap_taken, 1'b0);
        chk("rst_redirect", redirect_valid, 1'b0);
        chk("rst_illegal", csr_illegal, 1'b0);
        cycle();
        csr_rd_en = 0;
        wr(12'h340, 64'h5);
        rst = 0; ecall_trap_ena = 0;
        msip_i = 0; mtip_i = 0; meip_i = 0;
        rd("rst_mscratch", 12'h340, 64'h0);
        rd("rst_mstatus2", 12'h300, 64'h1800);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
